// File: rtl/fixed_point_divider.sv
// Sequential signed fixed-point divider: quotient = (dividend << FRAC) / divisor.
// Restoring division on magnitudes, one quotient bit per cycle, then sign fix-up and saturation.
module fixed_point_divider #(
    parameter int unsigned N    = 16,
    parameter int unsigned FRAC = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic         busy,
    output logic         finish,
    output logic         overflow,
    output logic         div_by_zero
);

    localparam int unsigned NW = N + FRAC;
    localparam int unsigned MW = N + 1;
    localparam int unsigned CW = $clog2(NW + 1);

    localparam logic [NW-1:0] MAG_POS = {{(FRAC + 1){1'b0}}, {(N - 1){1'b1}}};
    localparam logic [NW-1:0] MAG_NEG = MAG_POS + NW'(1);
    localparam logic [N-1:0]  SAT_POS = {1'b0, {(N - 1){1'b1}}};
    localparam logic [N-1:0]  SAT_NEG = {1'b1, {(N - 1){1'b0}}};

    typedef enum logic [1:0] {IDLE, DIVIDE, FIX, DONE} state_t;

    state_t          state;
    logic [NW-1:0]   num;
    logic [NW-1:0]   q;
    logic [MW-1:0]   rem;
    logic [MW-1:0]   dmag;
    logic [CW-1:0]   count;
    logic            neg;
    logic            dvd_neg;

    logic [MW-1:0]   dvd_ext_c;
    logic [MW-1:0]   dvs_ext_c;
    logic [MW-1:0]   dvd_mag_c;
    logic [MW-1:0]   dvs_mag_c;
    logic [MW-1:0]   rem_shift_c;
    logic [MW-1:0]   rem_next_c;
    logic            qbit_c;

    // Operand magnitudes in N+1 bits so the most negative value does not wrap
    always_comb begin
        dvd_ext_c = {dividend[N-1], dividend};
        dvs_ext_c = {divisor[N-1], divisor};
        dvd_mag_c = dvd_ext_c[MW-1] ? (~dvd_ext_c + MW'(1)) : dvd_ext_c;
        dvs_mag_c = dvs_ext_c[MW-1] ? (~dvs_ext_c + MW'(1)) : dvs_ext_c;
    end

    // One restoring step: remainder never exceeds the divisor magnitude, so its MSB is free
    always_comb begin
        rem_shift_c = {rem[MW-2:0], num[NW-1]};
        qbit_c      = (rem_shift_c >= dmag);
        rem_next_c  = qbit_c ? (rem_shift_c - dmag) : rem_shift_c;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            num         <= '0;
            q           <= '0;
            rem         <= '0;
            dmag        <= '0;
            count       <= '0;
            neg         <= 1'b0;
            dvd_neg     <= 1'b0;
            quotient    <= '0;
            busy        <= 1'b0;
            finish      <= 1'b0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        num         <= NW'(dvd_mag_c) << FRAC;
                        q           <= '0;
                        rem         <= '0;
                        dmag        <= dvs_mag_c;
                        count       <= '0;
                        neg         <= dividend[N-1] ^ divisor[N-1];
                        dvd_neg     <= dividend[N-1];
                        busy        <= 1'b1;
                        finish      <= 1'b0;
                        overflow    <= 1'b0;
                        div_by_zero <= (divisor == '0);
                        state       <= (divisor == '0) ? FIX : DIVIDE;
                    end
                end
                DIVIDE: begin
                    num   <= num << 1;
                    rem   <= rem_next_c;
                    q     <= {q[NW-2:0], qbit_c};
                    count <= count + CW'(1);
                    if (count == CW'(NW - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (div_by_zero) begin
                        quotient <= dvd_neg ? SAT_NEG : SAT_POS;
                        overflow <= 1'b0;
                    end else if (!neg && q > MAG_POS) begin
                        quotient <= SAT_POS;
                        overflow <= 1'b1;
                    end else if (neg && q > MAG_NEG) begin
                        quotient <= SAT_NEG;
                        overflow <= 1'b1;
                    end else begin
                        quotient <= neg ? (~q[N-1:0] + N'(1)) : q[N-1:0];
                        overflow <= 1'b0;
                    end
                    busy   <= 1'b0;
                    finish <= 1'b1;
                    state  <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_point_divider.sv
// Self-checking bench for fixed_point_divider: directed corner cases plus random operands
// compared against an integer-arithmetic reference model.
module tb_fixed_point_divider;

    localparam int unsigned N    = 16;
    localparam int unsigned FRAC = 10;
    localparam int          LAT  = N + FRAC + 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic [N-1:0] quotient;
    logic         busy;
    logic         finish;
    logic         overflow;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;

    fixed_point_divider #(.N(N), .FRAC(FRAC)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient   (quotient),
        .busy       (busy),
        .finish     (finish),
        .overflow   (overflow),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer quotient, truncated toward zero, then saturated
    task automatic model(input logic [N-1:0] a, input logic [N-1:0] b,
                         output logic [N-1:0] q, output logic ov, output logic dz);
        longint sa, sb, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ov = 1'b0;
        dz = 1'b0;
        if (sb == 0) begin
            dz = 1'b1;
            q  = (sa >= 0) ? 16'h7FFF : 16'h8000;
        end else begin
            r = (sa * (longint'(1) << FRAC)) / sb;
            if (r > 32767) begin
                q = 16'h7FFF; ov = 1'b1;
            end else if (r < -32768) begin
                q = 16'h8000; ov = 1'b1;
            end else begin
                q = 16'(r);
            end
        end
    endtask

    // Issue one operation; optionally pulse start (with junk operands) n cycles into it
    task automatic run(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] eq, input logic eov, input logic edz,
                       input int pulse_at);
        int n;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        chk({tag, "_busy"}, 32'(busy), 32'(1));
        chk({tag, "_fin_drop"}, 32'(finish), 32'(0));
        while (!finish && n < 60) begin
            if (n == pulse_at) begin
                start    = 1'b1;
                dividend = 16'h0400;
                divisor  = 16'h0C00;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk({tag, "_lat"}, 32'(n), (b == '0) ? 32'(1) : 32'(LAT));
        chk({tag, "_q"}, 32'(quotient), 32'(eq));
        chk({tag, "_ovf"}, 32'(overflow), 32'(eov));
        chk({tag, "_dz"}, 32'(div_by_zero), 32'(edz));
        chk({tag, "_idle"}, 32'(busy), 32'(0));
    endtask

    initial begin
        logic [N-1:0] ra, rb, eq;
        logic         eov, edz;

        reset    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        chk("rst_q", 32'(quotient), 32'(0));
        chk("rst_flags", {28'd0, busy, finish, overflow, div_by_zero}, 32'(0));
        reset = 1'b1;
        @(negedge clk);

        run("t1", 16'h0C00, 16'h0800, 16'h0600, 1'b0, 1'b0, -1);
        run("t2a", 16'hF400, 16'h0800, 16'hFA00, 1'b0, 1'b0, -1);
        run("t2b", 16'h0400, 16'h0C00, 16'h0155, 1'b0, 1'b0, -1);
        run("t3a", 16'h7800, 16'h0001, 16'h7FFF, 1'b1, 1'b0, -1);
        run("t3b", 16'h8000, 16'h0001, 16'h8000, 1'b1, 1'b0, -1);
        run("t3c", 16'h8000, 16'hFC00, 16'h7FFF, 1'b1, 1'b0, -1);
        run("t3d", 16'h8000, 16'h0400, 16'h8000, 1'b0, 1'b0, -1);
        run("t4a", 16'h1400, 16'h0000, 16'h7FFF, 1'b0, 1'b1, -1);
        run("t4b", 16'hEC00, 16'h0000, 16'h8000, 1'b0, 1'b1, -1);
        run("t5a", 16'h0C00, 16'h0800, 16'h0600, 1'b0, 1'b0, 10);
        run("t5b", 16'hF400, 16'h0C00, 16'hFC00, 1'b0, 1'b0, -1);

        // Reset in the middle of a divide
        @(negedge clk);
        dividend = 16'h0C00;
        divisor  = 16'h0800;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("t6_q", 32'(quotient), 32'(0));
        chk("t6_flags", {28'd0, busy, finish, overflow, div_by_zero}, 32'(0));
        repeat (30) @(negedge clk);
        chk("t6_stay", {28'd0, busy, finish, overflow, div_by_zero}, 32'(0));
        run("t6b", 16'h0400, 16'h0C00, 16'h0155, 1'b0, 1'b0, -1);

        for (int i = 0; i < 24; i++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = 16'($urandom_range(1, 255));
                1:       rb = 16'(-$urandom_range(1, 2048));
                2:       rb = (i == 5) ? 16'h0000 : 16'($urandom);
                default: rb = 16'($urandom);
            endcase
            model(ra, rb, eq, eov, edz);
            run($sformatf("rnd%0d", i), ra, rb, eq, eov, edz, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
